// File: rtl/vcu108_clk_gen.sv
// VCU108 fabric clock generator: differential clock receive, divide-by-DIVIDE with
// 50% duty (odd ratios use a falling-edge helper flop), lock timer and boundary-aligned gating.
module vcu108_clk_gen #(
    parameter int DIVIDE           = 3,
    parameter int LOCK_CYCLES      = 1024,
    parameter int CLK_IN_PERIOD_PS = 3333
) (
    input  logic clk_in1_p,
    input  logic clk_in1_n,
    input  logic reset,
    output logic locked,
    output logic clk_out1
);

    localparam int              CNT_W       = $clog2(DIVIDE);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DIVIDE - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH    = CNT_W'(DIVIDE / 2);
    localparam logic [15:0]      LOCK_TARGET = 16'(LOCK_CYCLES);
    localparam bit               ODD_DIVIDE  = (DIVIDE % 2) == 1;
    localparam int               unused_period_ps = CLK_IN_PERIOD_PS;

    logic clk_i;
    logic unused_clk_n;

    assign clk_i        = clk_in1_p;
    assign unused_clk_n = clk_in1_n;

    logic [CNT_W-1:0] div_cnt_q,  div_cnt_d;
    logic [15:0]      lock_cnt_q, lock_cnt_d;
    logic             raw_pos_q,  raw_pos_d;
    logic             locked_q,   locked_d;
    logic             gate_en_q,  gate_en_d;
    logic             raw_neg_q;
    logic             div_clk;

    // Lock and gate changes are only taken when the divider is about to start a new
    // period, so the first and last gated pulses are always full width.
    always_comb begin
        div_cnt_d  = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + 1'b1;
        lock_cnt_d = (lock_cnt_q < LOCK_TARGET) ? lock_cnt_q + 16'd1 : lock_cnt_q;
        raw_pos_d  = (div_cnt_d < CNT_HIGH);
        locked_d   = locked_q | ((lock_cnt_d == LOCK_TARGET) && (div_cnt_d == '0));
        gate_en_d  = (div_cnt_d == '0) ? locked_d : gate_en_q;
        if (reset) begin
            div_cnt_d  = '0;
            lock_cnt_d = '0;
            raw_pos_d  = 1'b0;
            locked_d   = 1'b0;
            gate_en_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        div_cnt_q  <= div_cnt_d;
        lock_cnt_q <= lock_cnt_d;
        raw_pos_q  <= raw_pos_d;
        locked_q   <= locked_d;
        gate_en_q  <= gate_en_d;
    end

    // Half-cycle delayed copy stretches odd-ratio high time by half an input period.
    always_ff @(negedge clk_i) begin
        raw_neg_q <= raw_pos_q;
    end

    assign div_clk  = raw_pos_q | (ODD_DIVIDE ? raw_neg_q : 1'b0);
    assign clk_out1 = div_clk & gate_en_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_vcu108_clk_gen.sv
// Bench for vcu108_clk_gen: three instances (DIVIDE 3/4/2) under randomized resets, checked
// every input half-period against a cycle-count model of the lock and divided waveform.
`timescale 1ps/1ps
module tb_vcu108_clk_gen;

    localparam int N         = 3;
    localparam int HALF_PS   = 1667;
    localparam int SAMPLE_PS = 800;
    localparam int DIV_P  [N] = '{3, 4, 2};
    localparam int LOCK_P [N] = '{16, 20, 1};

    logic         clk_p = 1'b0;
    logic         clk_n;
    logic [N-1:0] rst   = '0;
    logic [N-1:0] clk_out;
    logic [N-1:0] lk;
    logic [N-1:0] skip_out = '0;
    int           k [N];
    int           tests = 0;
    int           fails = 0;

    assign clk_n = ~clk_p;

    // Free-running ~300 MHz differential input.
    always #HALF_PS clk_p = ~clk_p;

    vcu108_clk_gen #(.DIVIDE(DIV_P[0]), .LOCK_CYCLES(LOCK_P[0]), .CLK_IN_PERIOD_PS(3333)) dut0 (
        .clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst[0]), .locked(lk[0]), .clk_out1(clk_out[0]));
    vcu108_clk_gen #(.DIVIDE(DIV_P[1]), .LOCK_CYCLES(LOCK_P[1]), .CLK_IN_PERIOD_PS(3333)) dut1 (
        .clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst[1]), .locked(lk[1]), .clk_out1(clk_out[1]));
    vcu108_clk_gen #(.DIVIDE(DIV_P[2]), .LOCK_CYCLES(LOCK_P[2]), .CLK_IN_PERIOD_PS(3333)) dut2 (
        .clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst[2]), .locked(lk[2]), .clk_out1(clk_out[2]));

    // k[i] = rising edges since the last reset edge (or since time zero).
    // Lock lands on the first multiple of DIVIDE at or after LOCK_CYCLES.
    function automatic logic exp_locked(input int i);
        int d      = DIV_P[i];
        int lock_k = ((LOCK_P[i] + d - 1) / d) * d;
        return (k[i] >= lock_k);
    endfunction

    // Output is high for the first DIVIDE half-periods of each DIVIDE-cycle period.
    function automatic logic exp_out(input int i, input int half);
        int d = DIV_P[i];
        return exp_locked(i) && ((2 * (k[i] % d) + half) < d);
    endfunction

    task automatic check_output(input int half);
        for (int i = 0; i < N; i++) begin
            tests++;
            assert (lk[i] === exp_locked(i)) else begin
                fails++;
                $error("[TB] FAIL locked dut%0d k=%0d half=%0d: got %b want %b",
                       i, k[i], half, lk[i], exp_locked(i));
            end
            if (!(half == 0 && skip_out[i])) begin
                tests++;
                assert (clk_out[i] === exp_out(i, half)) else begin
                    fails++;
                    $error("[TB] FAIL clk_out1 dut%0d k=%0d half=%0d: got %b want %b",
                           i, k[i], half, clk_out[i], exp_out(i, half));
                end
            end
        end
    endtask

    task automatic apply_stimulus(input logic [N-1:0] r, input int cycles);
        repeat (cycles) begin
            rst = r;
            @(posedge clk_p);
            for (int i = 0; i < N; i++) begin
                skip_out[i] = r[i] && (k[i] != 0);
                k[i]        = r[i] ? 0 : k[i] + 1;
            end
            #SAMPLE_PS check_output(0);
            @(negedge clk_p);
            #SAMPLE_PS check_output(1);
        end
    endtask

    initial begin
        logic [N-1:0] sel;
        logic [N-1:0] rnd;
        for (int i = 0; i < N; i++) k[i] = 0;

        #SAMPLE_PS check_output(1);
        apply_stimulus('0, 3);
        apply_stimulus('1, 4);
        apply_stimulus('0, 40 + int'($urandom_range(0, 10)));
        apply_stimulus('0, 300);

        for (int i = 0; i < N; i++) begin
            sel    = '0;
            sel[i] = 1'b1;
            apply_stimulus('0, int'($urandom_range(0, 5)));
            for (int w = 0; w < 20 && !exp_out(i, 1); w++) apply_stimulus('0, 1);
            apply_stimulus(sel, 1 + int'($urandom_range(0, 3)));
            apply_stimulus('0, 30);
        end

        apply_stimulus('1, 1000);
        apply_stimulus('0, 60);

        repeat (25) begin
            for (int i = 0; i < N; i++) rnd[i] = ($urandom_range(0, 3) == 0);
            apply_stimulus(rnd, 1 + int'($urandom_range(0, 5)));
            apply_stimulus('0, 5 + int'($urandom_range(0, 35)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
